busca_instrucao: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction-memory/decode path.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- On a taken branch, flushes all in-flight work and restarts at the target.

---
 rtl/busca_instrucao_pkg.sv | 13 +
 rtl/busca_instrucao_fila.sv | 46 ++++
 rtl/busca_instrucao.sv | 105 ++++++++++
 tb/tb_busca_instrucao.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared types and constants for the instruction fetch stage.
package busca_instrucao_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    DESCARTE = 2'd2
  } estado_busca_t;

  localparam int          LARGURA_PALAVRA = 32;
  localparam logic [31:0] INCREMENTO_PC   = 32'd4;

endpackage

// File: rtl/busca_instrucao_fila.sv
// Prefetch FIFO for fetched {instruction, pc} pairs; flush empties it in one cycle.
module fila_busca #(
  parameter  int LARGURA      = 64,
  parameter  int PROFUNDIDADE = 4,
  localparam int PW           = $clog2(PROFUNDIDADE),
  localparam int OW           = PW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [LARGURA-1:0] dado_entrada,
  output logic [LARGURA-1:0] dado_saida,
  output logic               vazia,
  output logic [OW-1:0]      ocupacao
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PW-1:0]      ptr_esc, ptr_lei;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      ocupacao <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
    end else if (flush) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      ocupacao <= '0;
    end else begin
      if (push) begin
        mem[ptr_esc] <= dado_entrada;
        ptr_esc      <= ptr_esc + 1'b1;
      end
      if (pop) ptr_lei <= ptr_lei + 1'b1;
      if (push && !pop)      ocupacao <= ocupacao + 1'b1;
      else if (pop && !push) ocupacao <= ocupacao - 1'b1;
    end
  end

  assign vazia      = (ocupacao == '0);
  assign dado_saida = mem[ptr_lei];

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: one outstanding memory request, prefetch FIFO, branch flush.
// Optional build macro BUSCA_DESALINHADO_EN adds erro_alinhamento for misaligned redirects.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int          PROFUNDIDADE = 4,
  parameter logic [31:0] PC_RESET     = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_ack,
  input  logic [31:0] mem_dado,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [31:0] instrucao,
  output logic [31:0] pc_instrucao,
  input  logic        desvio,
  input  logic [31:0] endereco_desvio
`ifdef BUSCA_DESALINHADO_EN
  ,
  output logic        erro_alinhamento
`endif
);

  localparam int            OW    = $clog2(PROFUNDIDADE) + 1;
  localparam logic [OW-1:0] CHEIO = OW'(PROFUNDIDADE);

  estado_busca_t                  estado, estado_prox;
  logic [31:0]                    pc_busca, alvo;
  logic                           erro, alvo_ok, emitir, push, pop, vazia;
  logic [OW-1:0]                  ocupacao;
  logic [2*LARGURA_PALAVRA-1:0]   cabeca;

`ifdef BUSCA_DESALINHADO_EN
  assign alvo    = endereco_desvio;
  assign alvo_ok = (endereco_desvio[1:0] == 2'b00);

  // Sticky until a later aligned redirect; blocks all new requests meanwhile.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      erro <= 1'b0;
    else if (desvio) erro <= !alvo_ok;
  end

  assign erro_alinhamento = erro;
`else
  logic alvo_lsb_unused;
  assign alvo_lsb_unused = |endereco_desvio[1:0];
  assign alvo            = {endereco_desvio[31:2], 2'b00};
  assign alvo_ok         = 1'b1;
  assign erro            = 1'b0;
`endif

  // A redirect flushes the FIFO, so occupancy does not gate a redirect issue.
  assign emitir = (estado == OCIOSO) &&
                  (desvio ? alvo_ok : (!erro && (ocupacao < CHEIO)));
  assign push   = (estado == ESPERA) && mem_ack && !desvio;
  assign pop    = !vazia && saida_pronta && !desvio;

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (emitir) estado_prox = ESPERA;
      ESPERA:   if (mem_ack) estado_prox = OCIOSO;
                else if (desvio) estado_prox = DESCARTE;
      DESCARTE: if (mem_ack) estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      pc_busca     <= PC_RESET;
      mem_endereco <= PC_RESET;
    end else begin
      estado <= estado_prox;
      if (desvio)    pc_busca <= alvo;
      else if (push) pc_busca <= pc_busca + INCREMENTO_PC;
      if (emitir)    mem_endereco <= desvio ? alvo : pc_busca;
    end
  end

  assign mem_req = (estado != OCIOSO);

  fila_busca #(
    .LARGURA      (2 * LARGURA_PALAVRA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fila (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .flush        (desvio),
    .dado_entrada ({mem_dado, mem_endereco}),
    .dado_saida   (cabeca),
    .vazia        (vazia),
    .ocupacao     (ocupacao)
  );

  assign saida_valida              = !vazia;
  assign {instrucao, pc_instrucao} = cabeca;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao (default depth 4, PC_RESET 0).
module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_ack = 1'b0;
  logic [31:0] mem_endereco, mem_dado = '0;
  logic        saida_valida, saida_pronta = 1'b0;
  logic [31:0] instrucao, pc_instrucao;
  logic        desvio = 1'b0;
  logic [31:0] endereco_desvio = '0;
`ifdef BUSCA_DESALINHADO_EN
  logic        erro_alinhamento;
`endif

  int n_verif = 0;
  int n_falhas = 0;

  busca_instrucao #(.PROFUNDIDADE(4), .PC_RESET(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_endereco    (mem_endereco),
    .mem_ack         (mem_ack),
    .mem_dado        (mem_dado),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .instrucao       (instrucao),
    .pc_instrucao    (pc_instrucao),
    .desvio          (desvio),
    .endereco_desvio (endereco_desvio)
`ifdef BUSCA_DESALINHADO_EN
    ,
    .erro_alinhamento(erro_alinhamento)
`endif
  );

  always #5 clock = ~clock;

  task automatic aplicar_reset();
    reset = 1'b0; mem_ack = 1'b0; desvio = 1'b0; mem_dado = '0; endereco_desvio = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Waits (bounded) for mem_req, sampled on the falling edge.
  task automatic esperar_req(output logic [31:0] ende, output int ciclos, output bit ok);
    ok = 1'b0; ciclos = 0; ende = 'x;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ciclos++;
      if (mem_req) begin ok = 1'b1; ende = mem_endereco; end
    end
  endtask

  task automatic enviar_ack(input int lat, input logic [31:0] d);
    repeat (lat) @(posedge clock);
    #1 mem_ack = 1'b1; mem_dado = d;
    @(posedge clock);
    #1 mem_ack = 1'b0; mem_dado = '0;
  endtask

  task automatic test_reset();
    #2;
    n_verif++;
    if (mem_req !== 1'b0 || mem_endereco !== 32'h0 || saida_valida !== 1'b0 ||
        instrucao !== 32'h0 || pc_instrucao !== 32'h0) begin
      n_falhas++;
      $display("FAIL reset_state: req=%b end=%h val=%b ins=%h pc=%h required 0/0/0/0/0",
               mem_req, mem_endereco, saida_valida, instrucao, pc_instrucao);
    end
  endtask

  task automatic test_sequencial();
    logic [31:0] e; int c; bit ok;
    aplicar_reset();
    saida_pronta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      esperar_req(e, c, ok);
      n_verif++;
      if (!ok || e !== 32'(4 * i)) begin
        n_falhas++;
        $display("FAIL seq_addr%0d: got %h ok=%0b required %h", i, e, ok, 32'(4 * i));
      end
      enviar_ack(2, 32'hA000_0000 + 32'(i));
      @(negedge clock);
      n_verif++;
      if (saida_valida !== 1'b1 || pc_instrucao !== 32'(4 * i) ||
          instrucao !== 32'hA000_0000 + 32'(i)) begin
        n_falhas++;
        $display("FAIL seq_head%0d: val=%b pc=%h ins=%h required 1 %h %h", i, saida_valida,
                 pc_instrucao, instrucao, 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_fifo_cheia();
    logic [31:0] e; int c; bit ok; bit req_visto;
    aplicar_reset();
    saida_pronta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      esperar_req(e, c, ok);
      n_verif++;
      if (!ok || e !== 32'(4 * i)) begin
        n_falhas++;
        $display("FAIL full_addr%0d: got %h ok=%0b required %h", i, e, ok, 32'(4 * i));
      end
      enviar_ack(1, 32'hC0DE_0000 + 32'(i));
    end
    req_visto = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (mem_req) req_visto = 1'b1;
    end
    n_verif++;
    if (req_visto !== 1'b0) begin
      n_falhas++;
      $display("FAIL full_no_req: mem_req seen=%b required 0", req_visto);
    end
    n_verif++;
    if (saida_valida !== 1'b1 || pc_instrucao !== 32'h0 || instrucao !== 32'hC0DE_0000) begin
      n_falhas++;
      $display("FAIL full_head: val=%b pc=%h ins=%h required 1 0 c0de0000",
               saida_valida, pc_instrucao, instrucao);
    end
    @(posedge clock); #1 saida_pronta = 1'b1;
    @(posedge clock); #1 saida_pronta = 1'b0;
    esperar_req(e, c, ok);
    n_verif++;
    if (!ok || e !== 32'h10 || pc_instrucao !== 32'h4) begin
      n_falhas++;
      $display("FAIL full_pop_refill: addr=%h ok=%0b head=%h required 10 1 4", e, ok, pc_instrucao);
    end
    enviar_ack(1, 32'hC0DE_0010);
  endtask

`ifndef BUSCA_DESALINHADO_EN
  // Continues from the full FIFO left by test_fifo_cheia: idle redirect, alignment, PC wrap.
  task automatic test_desvio_ocioso();
    logic [31:0] e; int c; bit ok;
    desvio = 1'b1; endereco_desvio = 32'hFFFF_FFFE;
    @(posedge clock); #1 desvio = 1'b0;
    @(negedge clock);
    n_verif++;
    if (mem_req !== 1'b1 || mem_endereco !== 32'hFFFF_FFFC || saida_valida !== 1'b0) begin
      n_falhas++;
      $display("FAIL idle_redirect: req=%b end=%h val=%b required 1 fffffffc 0",
               mem_req, mem_endereco, saida_valida);
    end
    enviar_ack(1, 32'hAAAA_5555);
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b1 || pc_instrucao !== 32'hFFFF_FFFC || instrucao !== 32'hAAAA_5555) begin
      n_falhas++;
      $display("FAIL idle_redirect_head: val=%b pc=%h ins=%h required 1 fffffffc aaaa5555",
               saida_valida, pc_instrucao, instrucao);
    end
    esperar_req(e, c, ok);
    n_verif++;
    if (!ok || e !== 32'h0) begin
      n_falhas++;
      $display("FAIL pc_wrap: got %h ok=%0b required 00000000", e, ok);
    end
    enviar_ack(1, 32'h0);
  endtask
`endif

  task automatic test_desvio_espera();
    logic [31:0] e; int c; bit ok;
    aplicar_reset();
    saida_pronta = 1'b0;
    esperar_req(e, c, ok);
    enviar_ack(1, 32'h0000_1111);
    esperar_req(e, c, ok);
    n_verif++;
    if (!ok || e !== 32'h4) begin
      n_falhas++;
      $display("FAIL flush_setup: got %h ok=%0b required 4", e, ok);
    end
    @(posedge clock); #1 desvio = 1'b1; endereco_desvio = 32'h100;
    @(posedge clock); #1 desvio = 1'b0;
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b0 || mem_req !== 1'b1 || mem_endereco !== 32'h4) begin
      n_falhas++;
      $display("FAIL flush_discard: val=%b req=%b end=%h required 0 1 4",
               saida_valida, mem_req, mem_endereco);
    end
    @(posedge clock); #1 mem_ack = 1'b1; mem_dado = 32'hDEAD;
    @(posedge clock); #1 mem_ack = 1'b0; mem_dado = '0;
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b0 || mem_req !== 1'b0) begin
      n_falhas++;
      $display("FAIL flush_dropped: val=%b req=%b required 0 0", saida_valida, mem_req);
    end
    esperar_req(e, c, ok);
    n_verif++;
    if (!ok || e !== 32'h100) begin
      n_falhas++;
      $display("FAIL flush_target: got %h ok=%0b required 100", e, ok);
    end
    enviar_ack(1, 32'h1234);
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b1 || pc_instrucao !== 32'h100 || instrucao !== 32'h1234) begin
      n_falhas++;
      $display("FAIL flush_head: val=%b pc=%h ins=%h required 1 100 1234",
               saida_valida, pc_instrucao, instrucao);
    end
  endtask

  task automatic test_desvio_com_ack();
    logic [31:0] e; int c; bit ok;
    aplicar_reset();
    saida_pronta = 1'b1;
    esperar_req(e, c, ok);
    @(posedge clock);
    #1 mem_ack = 1'b1; mem_dado = 32'hBEEF; desvio = 1'b1; endereco_desvio = 32'h200;
    @(posedge clock);
    #1 mem_ack = 1'b0; mem_dado = '0; desvio = 1'b0;
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b0 || mem_req !== 1'b0) begin
      n_falhas++;
      $display("FAIL ack_redirect_drop: val=%b req=%b required 0 0", saida_valida, mem_req);
    end
    esperar_req(e, c, ok);
    n_verif++;
    if (!ok || e !== 32'h200 || c !== 1) begin
      n_falhas++;
      $display("FAIL ack_redirect_target: addr=%h ok=%0b wait=%0d required 200 1 1", e, ok, c);
    end
    enviar_ack(1, 32'h2000_0001);
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b1 || pc_instrucao !== 32'h200 || instrucao !== 32'h2000_0001) begin
      n_falhas++;
      $display("FAIL ack_redirect_head: val=%b pc=%h ins=%h required 1 200 20000001",
               saida_valida, pc_instrucao, instrucao);
    end
  endtask

  task automatic test_reset_meio();
    logic [31:0] e; int c; bit ok;
    aplicar_reset();
    saida_pronta = 1'b0;
    esperar_req(e, c, ok);
    enviar_ack(1, 32'h5555);
    esperar_req(e, c, ok);
    reset = 1'b0;
    #1;
    n_verif++;
    if (mem_req !== 1'b0 || saida_valida !== 1'b0 || pc_instrucao !== 32'h0) begin
      n_falhas++;
      $display("FAIL async_reset: req=%b val=%b pc=%h required 0 0 0", mem_req, saida_valida, pc_instrucao);
    end
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b1; mem_ack = 1'b1; mem_dado = 32'h5AFE;
    @(posedge clock); #1 mem_ack = 1'b0; mem_dado = '0;
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b0 || mem_req !== 1'b1 || mem_endereco !== 32'h0) begin
      n_falhas++;
      $display("FAIL stale_ack: val=%b req=%b end=%h required 0 1 0", saida_valida, mem_req, mem_endereco);
    end
    enviar_ack(1, 32'h600D);
    @(negedge clock);
    n_verif++;
    if (saida_valida !== 1'b1 || pc_instrucao !== 32'h0 || instrucao !== 32'h600D) begin
      n_falhas++;
      $display("FAIL post_reset_head: val=%b pc=%h ins=%h required 1 0 600d",
               saida_valida, pc_instrucao, instrucao);
    end
  endtask

`ifdef BUSCA_DESALINHADO_EN
  task automatic test_desalinhado();
    logic [31:0] e; int c; bit ok; bit req_visto;
    aplicar_reset();
    saida_pronta = 1'b1;
    desvio = 1'b1; endereco_desvio = 32'h102;
    @(posedge clock); #1 desvio = 1'b0;
    @(negedge clock);
    n_verif++;
    if (erro_alinhamento !== 1'b1 || mem_req !== 1'b0) begin
      n_falhas++;
      $display("FAIL misalign_set: err=%b req=%b required 1 0", erro_alinhamento, mem_req);
    end
    req_visto = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (mem_req) req_visto = 1'b1;
    end
    n_verif++;
    if (req_visto !== 1'b0) begin
      n_falhas++;
      $display("FAIL misalign_block: mem_req seen=%b required 0", req_visto);
    end
    @(posedge clock); #1 desvio = 1'b1; endereco_desvio = 32'h300;
    @(posedge clock); #1 desvio = 1'b0;
    @(negedge clock);
    n_verif++;
    if (erro_alinhamento !== 1'b0 || mem_req !== 1'b1 || mem_endereco !== 32'h300) begin
      n_falhas++;
      $display("FAIL misalign_clear: err=%b req=%b end=%h required 0 1 300",
               erro_alinhamento, mem_req, mem_endereco);
    end
    enviar_ack(1, 32'h3003);
  endtask
`endif

  initial begin
    test_reset();
    test_sequencial();
    test_fifo_cheia();
`ifndef BUSCA_DESALINHADO_EN
    test_desvio_ocioso();
`endif
    test_desvio_espera();
    test_desvio_com_ack();
    test_reset_meio();
`ifdef BUSCA_DESALINHADO_EN
    test_desalinhado();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule
